// File: rtl/wb_trace_buffer.sv
// Circular capture buffer for CPU writeback events, frozen a fixed number of samples after a PC trigger.
// Optional: define WB_TRACE_SKIP_X0_EN to drop writebacks to x0 entirely.
module wb_trace_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8,
  localparam int unsigned ENTRY_W  = ADDR_W + 5 + DATA_W,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [ADDR_W-1:0]  trig_pc,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic [ADDR_W-1:0]  wb_pc,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [IDX_W:0]     count,
  output logic [IDX_W-1:0]   trig_idx,
  output logic               capturing,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StPretrig, StPosttrig, StDone} state_e;

  localparam logic [IDX_W:0]   CountFull   = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] PostInit    = IDX_W'(POST_TRIG);
  localparam logic [IDX_W-1:0] TrigIdxWrap = IDX_W'(DEPTH - 1 - POST_TRIG);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]     count_q, count_d;
  logic [IDX_W-1:0]   post_cnt_q, post_cnt_d;
  logic [IDX_W-1:0]   trig_idx_q, trig_idx_d;
  logic               capturing_q, done_q;
  logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic               in_capture;
  logic               sample;
  logic               trig_hit;
  logic               mem_we;
  logic               will_wrap;
  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   rd_addr;

  assign in_capture = (state_q == StPretrig) || (state_q == StPosttrig);
`ifdef WB_TRACE_SKIP_X0_EN
  assign sample     = wb_valid && in_capture && (wb_rd != 5'd0);
`else
  assign sample     = wb_valid && in_capture;
`endif
  assign trig_hit   = (state_q == StPretrig) && ((wb_pc == trig_pc) || force_trig);
  // Buffer will be full when frozen, so the final base is the write pointer after the
  // post-trigger samples and the trigger sits a fixed distance back from the newest entry.
  assign will_wrap  = (32'(count_q) + 32'd1 + POST_TRIG) >= DEPTH;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_idx_d = trig_idx_q;
    mem_we     = 1'b0;
    if (arm) begin
      state_d    = StPretrig;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      trig_idx_d = '0;
    end else if (sample) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != CountFull) begin
        count_d = count_q + 1'b1;
      end
      if (trig_hit) begin
        trig_idx_d = will_wrap ? TrigIdxWrap : wr_ptr_q;
        if (POST_TRIG == 0) begin
          state_d = StDone;
        end else begin
          state_d    = StPosttrig;
          post_cnt_d = PostInit;
        end
      end else if (state_q == StPosttrig) begin
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == IDX_W'(1)) begin
          state_d = StDone;
        end
      end
    end
  end

  // Oldest entry is slot 0 until the buffer wraps, then it is the next slot to be written.
  assign base    = (count_q == CountFull) ? wr_ptr_q : '0;
  assign rd_addr = base + rd_idx;

  always_comb begin
    rd_entry_d = '0;
    if ({1'b0, rd_idx} < count_q) begin
      rd_entry_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      trig_idx_q  <= '0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
      rd_entry_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      trig_idx_q  <= trig_idx_d;
      capturing_q <= (state_d == StPretrig) || (state_d == StPosttrig);
      done_q      <= (state_d == StDone);
      rd_entry_q  <= rd_entry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wr_ptr_q] <= {wb_pc, wb_rd, wb_data};
    end
  end

  assign rd_entry  = rd_entry_q;
  assign count     = count_q;
  assign trig_idx  = trig_idx_q;
  assign capturing = capturing_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: DEPTH=8 with POST_TRIG=2 and POST_TRIG=0 instances on shared stimulus.
module tb_wb_trace_buffer;

  localparam int unsigned EW = 49;

  logic          clk = 1'b0;
  logic          rst, arm, force_trig, wb_valid;
  logic [11:0]   trig_pc, wb_pc;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [2:0]    rd_idx;
  logic [EW-1:0] rd_entry, rd_entry0;
  logic [3:0]    count, count0;
  logic [2:0]    trig_idx, trig_idx0;
  logic          capturing, capturing0, done, done0;

  int n_vec  = 0;
  int n_miss = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] want, got;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DATA_W(32), .ADDR_W(12), .DEPTH(8), .POST_TRIG(2)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .force_trig(force_trig), .trig_pc(trig_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .rd_idx(rd_idx),
    .rd_entry(rd_entry), .count(count), .trig_idx(trig_idx), .capturing(capturing), .done(done)
  );

  wb_trace_buffer #(.DATA_W(32), .ADDR_W(12), .DEPTH(8), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst(rst), .arm(arm), .force_trig(force_trig), .trig_pc(trig_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .rd_idx(rd_idx),
    .rd_entry(rd_entry0), .count(count0), .trig_idx(trig_idx0), .capturing(capturing0),
    .done(done0)
  );

  function automatic logic [EW-1:0] mk(input logic [11:0] pc);
    return {pc, pc[6:2] + 5'd1, 32'hA500_0000 | {20'd0, pc}};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic wr_raw(input logic [11:0] pc, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_rd    = rd;
    wb_data  = data;
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic wr(input logic [11:0] pc);
    logic [EW-1:0] e;
    e = mk(pc);
    wr_raw(pc, e[36:32], e[31:0]);
  endtask

  task automatic issue_rd(input int idx, input logic [EW-1:0] exp);
    rd_idx = 3'(idx);
    exp_q.push_back(exp);
    cyc();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    arm = 1'b1;
    cyc();
    cyc();
    arm = 1'b0;
    n_vec++;
    if ({count, capturing, done, trig_idx} !== 9'd0 || rd_entry !== '0) begin
      $display("FAIL reset: cnt=%0d cap=%0b done=%0b tidx=%0d ent=%0h want all 0",
               count, capturing, done, trig_idx, rd_entry);
      n_miss++;
    end
    rst = 1'b0;
    wr(12'h000);
    n_vec++;
    if (count !== 4'd0 || capturing !== 1'b0) begin
      $display("FAIL idle_write: cnt=%0d cap=%0b want 0 0", count, capturing);
      n_miss++;
    end
  endtask

  task automatic test_basic;
    trig_pc = 12'hFFF;
    do_arm();
    wr(12'h000);
    wr(12'h004);
    wr(12'h008);
    n_vec++;
    if (count !== 4'd3 || capturing !== 1'b1 || done !== 1'b0) begin
      $display("FAIL basic_state: cnt=%0d cap=%0b done=%0b want 3 1 0", count, capturing, done);
      n_miss++;
    end
    issue_rd(1, mk(12'h004));
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL basic_rd1: got %0h want %0h", got, want);
      n_miss++;
    end
  endtask

  task automatic test_wrap;
    do_arm();
    for (int i = 0; i < 11; i++) wr(12'(i * 4));
    n_vec++;
    if (count !== 4'd8) begin
      $display("FAIL wrap_count: got %0d want 8", count);
      n_miss++;
    end
    issue_rd(0, mk(12'h00C));
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL wrap_rd0: got %0h want %0h", got, want);
      n_miss++;
    end
    issue_rd(7, mk(12'h028));
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL wrap_rd7: got %0h want %0h", got, want);
      n_miss++;
    end
  endtask

  task automatic test_trigger;
    trig_pc = 12'h010;
    do_arm();
    for (int i = 0; i < 13; i++) begin
      wr(12'(i * 4));
      if (i == 5 || i == 6) begin
        n_vec++;
        if (done !== (i == 6)) begin
          $display("FAIL trig_done_at_%0d: got %0b want %0b", i, done, (i == 6));
          n_miss++;
        end
      end
    end
    n_vec++;
    if (count !== 4'd7 || trig_idx !== 3'd4 || capturing !== 1'b0) begin
      $display("FAIL trig_state: cnt=%0d tidx=%0d cap=%0b want 7 4 0", count, trig_idx, capturing);
      n_miss++;
    end
    n_vec++;
    if (done0 !== 1'b1 || count0 !== 4'd5 || trig_idx0 !== 3'd4) begin
      $display("FAIL trig_p0: done=%0b cnt=%0d tidx=%0d want 1 5 4", done0, count0, trig_idx0);
      n_miss++;
    end
    issue_rd(6, mk(12'h018));
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL trig_rd6: got %0h want %0h", got, want);
      n_miss++;
    end
    issue_rd(7, '0);
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL trig_rd_beyond: got %0h want %0h", got, want);
      n_miss++;
    end
  endtask

  task automatic test_trig_wrap;
    trig_pc = 12'h024;
    do_arm();
    for (int i = 0; i < 12; i++) wr(12'(i * 4));
    n_vec++;
    if (done !== 1'b1 || count !== 4'd8 || trig_idx !== 3'd5) begin
      $display("FAIL twrap_state: done=%0b cnt=%0d tidx=%0d want 1 8 5", done, count, trig_idx);
      n_miss++;
    end
    n_vec++;
    if (trig_idx0 !== 3'd7) begin
      $display("FAIL twrap_p0_tidx: got %0d want 7", trig_idx0);
      n_miss++;
    end
    issue_rd(5, mk(12'h024));
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL twrap_rd5: got %0h want %0h", got, want);
      n_miss++;
    end
    issue_rd(0, mk(12'h010));
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL twrap_rd0: got %0h want %0h", got, want);
      n_miss++;
    end
  endtask

  task automatic test_rearm;
    trig_pc = 12'h000;
    do_arm();
    wr(12'h000);
    wr(12'h004);
    n_vec++;
    if (capturing !== 1'b1 || done !== 1'b0 || count !== 4'd2) begin
      $display("FAIL rearm_pre: cap=%0b done=%0b cnt=%0d want 1 0 2", capturing, done, count);
      n_miss++;
    end
    do_arm();
    n_vec++;
    if (capturing !== 1'b1 || done !== 1'b0 || count !== 4'd0) begin
      $display("FAIL rearm_post: cap=%0b done=%0b cnt=%0d want 1 0 0", capturing, done, count);
      n_miss++;
    end
    issue_rd(0, '0);
    got = rd_entry; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL rearm_rd0: got %0h want %0h", got, want);
      n_miss++;
    end
  endtask

  task automatic test_force;
    trig_pc = 12'hFFF;
    do_arm();
    force_trig = 1'b1;
    wr_raw(12'h020, 5'd5, 32'hDEADBEEF);
    force_trig = 1'b0;
    n_vec++;
    if (done0 !== 1'b1 || capturing0 !== 1'b0) begin
      $display("FAIL force_p0_done: done=%0b cap=%0b want 1 0", done0, capturing0);
      n_miss++;
    end
    n_vec++;
    if (done !== 1'b0 || capturing !== 1'b1) begin
      $display("FAIL force_p2_post: done=%0b cap=%0b want 0 1", done, capturing);
      n_miss++;
    end
    issue_rd(0, {12'h020, 5'd5, 32'hDEADBEEF});
    got = rd_entry0; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL force_rd0: got %0h want %0h", got, want);
      n_miss++;
    end
  endtask

  task automatic test_skip_x0;
    trig_pc = 12'h040;
    do_arm();
    wr_raw(12'h040, 5'd0, 32'h0000_1234);
`ifdef WB_TRACE_SKIP_X0_EN
    n_vec++;
    if (count0 !== 4'd0 || done0 !== 1'b0 || capturing0 !== 1'b1) begin
      $display("FAIL x0_skipped: cnt=%0d done=%0b cap=%0b want 0 0 1", count0, done0, capturing0);
      n_miss++;
    end
`else
    n_vec++;
    if (count0 !== 4'd1 || done0 !== 1'b1) begin
      $display("FAIL x0_captured: cnt=%0d done=%0b want 1 1", count0, done0);
      n_miss++;
    end
    issue_rd(0, {12'h040, 5'd0, 32'h0000_1234});
    got = rd_entry0; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      $display("FAIL x0_rd0: got %0h want %0h", got, want);
      n_miss++;
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    arm        = 1'b0;
    force_trig = 1'b0;
    trig_pc    = 12'hFFF;
    wb_valid   = 1'b0;
    wb_rd      = 5'd0;
    wb_data    = 32'd0;
    wb_pc      = 12'd0;
    rd_idx     = 3'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_trigger();
    test_trig_wrap();
    test_rearm();
    test_force();
    test_skip_x0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
